rptr_empty_sync: RTL

RPTR_EMPTY_SYNC -- requirements
Module: rptr_empty_sync

---
 rtl/rptr_empty_sync.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rptr_empty_sync.sv
// Read-side pointer and empty logic for an asynchronous FIFO.
// Synchronizes the Gray write pointer into rd_clk, advances the binary and
// Gray read pointers, and produces registered empty/level/underflow status.
// Optional feature macro: RPTR_LEVEL_EN (builds rlevel and ralmost_empty from
// the synchronized write pointer; without it rlevel is 0 and
// ralmost_empty follows rempty).
module rptr_empty_sync #(
    parameter int ASIZE    = 4,
    parameter int AE_LEVEL = 2
) (
    input  logic             rd_clk,
    input  logic             rrst_n,
    input  logic             rd_en,
    input  logic [ASIZE:0]   wptr_async,
    input  logic             rd_err_clr,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE:0]   rlevel,
    output logic             rd_underflow
);

    // Two-flop synchronizer stages; r_sync2 is the usable s_wptr.
    logic [ASIZE:0] r_sync1;
    logic [ASIZE:0] r_sync2;

    logic [ASIZE:0] r_rbin;
    logic [ASIZE:0] r_rptr;
    logic           r_rempty;
    logic           r_underflow;

    logic           w_rd_inc;
    logic [ASIZE:0] w_bnext;
    logic [ASIZE:0] w_gnext;

    // A read only advances the pointer when there is data to read.
    assign w_rd_inc = rd_en & ~r_rempty;
    assign w_bnext  = r_rbin + {{ASIZE{1'b0}}, w_rd_inc};
    assign w_gnext  = (w_bnext >> 1) ^ w_bnext;

    // Bring the write pointer into the read domain.
    always_ff @(posedge rd_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= wptr_async;
            r_sync2 <= r_sync1;
        end
    end

    // Pointer advance and empty detection; empty uses the next pointer so
    // reading the last entry raises rempty at the same edge.
    always_ff @(posedge rd_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin   <= '0;
            r_rptr   <= '0;
            r_rempty <= 1'b1;
        end else begin
            r_rbin   <= w_bnext;
            r_rptr   <= w_gnext;
            r_rempty <= (w_gnext == r_sync2);
        end
    end

    // Sticky underflow: a new underflow takes priority over a clear.
    always_ff @(posedge rd_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_underflow <= 1'b0;
        end else if (rd_en && r_rempty) begin
            r_underflow <= 1'b1;
        end else if (rd_err_clr) begin
            r_underflow <= 1'b0;
        end
    end

`ifdef RPTR_LEVEL_EN
    localparam logic [ASIZE:0] AE_LVL = (ASIZE+1)'(AE_LEVEL);

    logic [ASIZE:0] w_sbin;
    logic [ASIZE:0] w_level_next;
    logic [ASIZE:0] r_rlevel;
    logic           r_ralmost_empty;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_sbin = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            w_sbin[i] = ^(r_sync2 >> i);
        end
    end

    // The synchronized write pointer lags, so this level never overstates data.
    assign w_level_next = w_sbin - w_bnext;

    // Register level and almost-empty alongside the pointer update.
    always_ff @(posedge rd_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rlevel        <= '0;
            r_ralmost_empty <= 1'b1;
        end else begin
            r_rlevel        <= w_level_next;
            r_ralmost_empty <= (w_level_next <= AE_LVL);
        end
    end

    assign rlevel        = r_rlevel;
    assign ralmost_empty = r_ralmost_empty;
`else
    assign rlevel        = '0;
    assign ralmost_empty = r_rempty;
`endif

    assign rempty       = r_rempty;
    assign raddr        = r_rbin[ASIZE-1:0];
    assign rptr         = r_rptr;
    assign rd_underflow = r_underflow;

endmodule
